// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan driver: glyph constants
// (active-low, bit order gfedcba) and the PWM on-window calculation.
package seg_pkg;

  localparam int unsigned GLYPH_W = 7;

  localparam logic [GLYPH_W-1:0] SEG_OFF     = 7'b111_1111;
  localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 7'b111_1111;
  localparam logic [GLYPH_W-1:0] GLYPH_DASH  = 7'b011_1111;

  localparam logic [GLYPH_W-1:0] GLYPH_0 = 7'b100_0000;
  localparam logic [GLYPH_W-1:0] GLYPH_1 = 7'b111_1001;
  localparam logic [GLYPH_W-1:0] GLYPH_2 = 7'b010_0100;
  localparam logic [GLYPH_W-1:0] GLYPH_3 = 7'b011_0000;
  localparam logic [GLYPH_W-1:0] GLYPH_4 = 7'b001_1001;
  localparam logic [GLYPH_W-1:0] GLYPH_5 = 7'b001_0010;
  localparam logic [GLYPH_W-1:0] GLYPH_6 = 7'b000_0010;
  localparam logic [GLYPH_W-1:0] GLYPH_7 = 7'b111_1000;
  localparam logic [GLYPH_W-1:0] GLYPH_8 = 7'b000_0000;
  localparam logic [GLYPH_W-1:0] GLYPH_9 = 7'b001_0000;
  localparam logic [GLYPH_W-1:0] GLYPH_A = 7'b000_1000;
  localparam logic [GLYPH_W-1:0] GLYPH_B = 7'b000_0011;
  localparam logic [GLYPH_W-1:0] GLYPH_C = 7'b100_0110;
  localparam logic [GLYPH_W-1:0] GLYPH_D = 7'b010_0001;
  localparam logic [GLYPH_W-1:0] GLYPH_E = 7'b000_0110;
  localparam logic [GLYPH_W-1:0] GLYPH_F = 7'b000_1110;

  // Hex nibble to active-low glyph.
  function automatic logic [GLYPH_W-1:0] hex_glyph(input logic [3:0] v);
    logic [GLYPH_W-1:0] g;
    g = SEG_OFF;
    case (v)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

  // First slot count after the lit window; 32-bit math never overflows for legal slot sizes.
  function automatic logic [31:0] calc_on_end(input int unsigned slot_clks,
                                              input int unsigned dead_clks,
                                              input logic [3:0]  bright);
    logic [31:0] span;
    span = 32'(slot_clks - dead_clks) * (32'(bright) + 32'd1);
    return 32'(dead_clks) + (span >> 4);
  endfunction

endpackage

// File: rtl/seg_pwm_slot.sv
// Slot/digit scan counters and the per-cycle "digit lit" decision
// (dead time, brightness window, blanking).
module seg_pwm_slot
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned SLOT_CLKS = 1024,
  parameter int unsigned DEAD_CLKS = 8,
  localparam int unsigned IDX_W    = $clog2(N_DIGITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          bright,
  input  logic [N_DIGITS-1:0] blank,
  output logic                lit_c,
  output logic [IDX_W-1:0]    dig_idx,
  output logic                frame_start_c,
  output logic                frame_end_c
);

  localparam int unsigned CNT_W = $clog2(SLOT_CLKS);
  localparam int unsigned ON_W  = CNT_W + 5;

  logic [CNT_W-1:0] slot_cnt;
  logic             slot_last_c;
  logic             dig_last_c;
  logic [ON_W-1:0]  slot_ext_c;
  logic [ON_W-1:0]  on_end_c;

  assign slot_last_c = (slot_cnt == CNT_W'(SLOT_CLKS - 1));
  assign dig_last_c  = (dig_idx == IDX_W'(N_DIGITS - 1));

  // Slot counter wraps into the next digit; digit index wraps into the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_last_c) begin
      slot_cnt <= '0;
      dig_idx  <= dig_last_c ? '0 : dig_idx + IDX_W'(1);
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  assign slot_ext_c = ON_W'(slot_cnt);
  assign on_end_c   = ON_W'(calc_on_end(SLOT_CLKS, DEAD_CLKS, bright));

  always_comb begin
    lit_c = 1'b0;
    if ((slot_ext_c >= ON_W'(DEAD_CLKS)) && (slot_ext_c < on_end_c)) begin
      lit_c = ~blank[dig_idx];
    end
  end

  assign frame_start_c = (slot_cnt == '0) && (dig_idx == '0);
  assign frame_end_c   = slot_last_c && dig_last_c;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with frame snapshot, PWM and blanking.
// Define SEG_SCAN_BLINK_EN to add blink_mask and a 64-frame blink cadence.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned SEG_W     = 7,
  parameter int unsigned SLOT_CLKS = 1024,
  parameter int unsigned DEAD_CLKS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_DIGITS*SEG_W-1:0] reel_segs,
  input  logic [N_DIGITS*SEG_W-1:0] bal_segs,
  input  logic                      show_bal,
  input  logic [N_DIGITS-1:0]       blank_mask,
  input  logic [3:0]                bright,
  output logic [SEG_W-1:0]          seg,
  output logic [N_DIGITS-1:0]       an,
  output logic                      frame_start
`ifdef SEG_SCAN_BLINK_EN
  ,
  input  logic [N_DIGITS-1:0]       blink_mask
`endif
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned PAT_W = N_DIGITS * SEG_W;

  logic                first_q;
  logic [PAT_W-1:0]    snap_pat;
  logic [N_DIGITS-1:0] snap_blank;
  logic [3:0]          snap_bright;
  logic [N_DIGITS-1:0] blank_eff_c;
  logic [PAT_W-1:0]    sel_pat_c;
  logic                snap_take_c;
  logic                lit_c;
  logic                frame_start_c;
  logic                frame_end_c;
  logic [IDX_W-1:0]    dig_idx;

  assign sel_pat_c   = show_bal ? bal_segs : reel_segs;
  assign snap_take_c = first_q | frame_end_c;

  // Marks the first cycle after reset release so the snapshot loads immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
    end
  end

  // Frame-consistent copy of the display inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_pat    <= '1;
      snap_blank  <= '1;
      snap_bright <= '1;
    end else if (snap_take_c) begin
      snap_pat    <= sel_pat_c;
      snap_blank  <= blank_mask;
      snap_bright <= bright;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  logic [N_DIGITS-1:0] snap_blink;
  logic [5:0]          frame_cnt;

  // Bit 5 of the frame count gives 32 frames visible, 32 frames dark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_blink <= '1;
      frame_cnt  <= '0;
    end else begin
      if (snap_take_c) begin
        snap_blink <= blink_mask;
      end
      if (frame_end_c) begin
        frame_cnt <= frame_cnt + 6'(1);
      end
    end
  end

  assign blank_eff_c = snap_blank | (snap_blink & {N_DIGITS{frame_cnt[5]}});
`else
  assign blank_eff_c = snap_blank;
`endif

  seg_pwm_slot #(
    .N_DIGITS  (N_DIGITS),
    .SLOT_CLKS (SLOT_CLKS),
    .DEAD_CLKS (DEAD_CLKS)
  ) u_slot (
    .clk           (clk),
    .rst_n         (rst_n),
    .bright        (snap_bright),
    .blank         (blank_eff_c),
    .lit_c         (lit_c),
    .dig_idx       (dig_idx),
    .frame_start_c (frame_start_c),
    .frame_end_c   (frame_end_c)
  );

  // Pin registers: dark unless the current digit is inside its lit window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg         <= '1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_start_c;
      if (lit_c) begin
        an  <= ~(N_DIGITS'(1) << dig_idx);
        seg <= snap_pat[dig_idx*SEG_W +: SEG_W];
      end else begin
        an  <= '1;
        seg <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a time-indexed reference model pushes the
// expected pins at each clock edge; each scenario task pops and compares.
module tb_seg_scan_mux;
  import seg_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 7;
  localparam int unsigned SLOT  = 32;
  localparam int unsigned DEAD  = 4;
  localparam int unsigned FRAME = N * SLOT;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] reel_segs = '1;
  logic [N*W-1:0] bal_segs = '1;
  logic           show_bal = 1'b0;
  logic [N-1:0]   blank_mask = '0;
  logic [3:0]     bright = 4'hF;
  logic [W-1:0]   seg;
  logic [N-1:0]   an;
  logic           frame_start;
`ifdef SEG_SCAN_BLINK_EN
  logic [N-1:0]   blink_mask = '0;
`endif

  seg_scan_mux #(
    .N_DIGITS  (N),
    .SEG_W     (W),
    .SLOT_CLKS (SLOT),
    .DEAD_CLKS (DEAD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reel_segs   (reel_segs),
    .bal_segs    (bal_segs),
    .show_bal    (show_bal),
    .blank_mask  (blank_mask),
    .bright      (bright),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
`ifdef SEG_SCAN_BLINK_EN
    ,
    .blink_mask  (blink_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] an;
    logic [W-1:0] seg;
    logic         fs;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   errors = 0;

  // Reference model state: k = clocks since reset release, m_* = frame snapshot.
  int unsigned    k = 0;
  logic [N*W-1:0] m_pat = '1;
  logic [N-1:0]   m_blank = '1;
  logic [N-1:0]   m_blink = '1;
  logic [3:0]     m_bright = 4'hF;

  task automatic model_step();
    exp_t        e;
    int unsigned slot, dig, fr, on_end;
    logic        lit;
    if (!rst_n) begin
      e = '1;
      e.fs = 1'b0;
      k = 0;
      m_pat = '1;
      m_blank = '1;
      m_blink = '1;
      m_bright = 4'hF;
    end else begin
      slot   = k % SLOT;
      dig    = (k / SLOT) % N;
      fr     = k / FRAME;
      on_end = DEAD + ((SLOT - DEAD) * (int'(m_bright) + 1)) / 16;
      lit    = (slot >= DEAD) && (slot < on_end) && !m_blank[dig];
`ifdef SEG_SCAN_BLINK_EN
      if (m_blink[dig] && ((fr / 32) % 2 == 1)) lit = 1'b0;
`endif
      e.an  = lit ? ~(N'(1) << dig) : '1;
      e.seg = lit ? m_pat[dig*W +: W] : '1;
      e.fs  = (k % FRAME == 0);
      if (k == 0 || (k % FRAME) == FRAME - 1) begin
        m_pat    = show_bal ? bal_segs : reel_segs;
        m_blank  = blank_mask;
        m_bright = bright;
`ifdef SEG_SCAN_BLINK_EN
        m_blink  = blink_mask;
`endif
      end
      k++;
    end
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic test_reset();
    exp_t e;
    int   first_lit = -1;
    rst_n = 1'b0;
    bright = 4'hF;
    blank_mask = '0;
    show_bal = 1'b0;
    for (int i = 0; i < N; i++) begin
      reel_segs[i*W +: W] = hex_glyph(4'(i));
      bal_segs[i*W +: W]  = hex_glyph(4'(i + 8));
    end
    @(negedge clk);
    sb_q.delete();
    for (int c = 0; c < 3 + 2 * FRAME; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({an, seg, frame_start} !== e) begin
        errors++;
        $display("FAIL reset_release c=%0d: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                 c, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      if (c < 3) begin
        vectors++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || frame_start !== 1'b0) begin
          errors++;
          $display("FAIL reset_values c=%0d: got an=%b seg=%b fs=%b, want 1111 1111111 0",
                   c, an, seg, frame_start);
        end
      end
      if (first_lit < 0 && an === 4'b1110) first_lit = c;
      if (c == 2) rst_n = 1'b1;
    end
    vectors++;
    if (first_lit != 7) begin
      errors++;
      $display("FAIL first_lit_latency: got cycle %0d, want 7", first_lit);
    end
  endtask

  task automatic test_bright0();
    exp_t e;
    int   lit_cnt = 0;
    bright = 4'h0;
    @(negedge clk);
    sb_q.delete();
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({an, seg, frame_start} !== e) begin
        errors++;
        $display("FAIL bright0 c=%0d: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                 c, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      if (c >= 2 * FRAME && an !== 4'b1111) lit_cnt++;
    end
    vectors++;
    if (lit_cnt != N) begin
      errors++;
      $display("FAIL bright0_lit_count: got %0d lit clocks per frame, want %0d", lit_cnt, N);
    end
    bright = 4'hF;
  endtask

  task automatic test_show_bal();
    exp_t e;
    reel_segs[1*W +: W] = 7'b1111001;
    bal_segs[1*W +: W]  = 7'b0100100;
    show_bal = 1'b0;
    @(negedge clk);
    sb_q.delete();
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({an, seg, frame_start} !== e) begin
        errors++;
        $display("FAIL show_bal c=%0d: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                 c, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      if (c == FRAME + 40) show_bal = 1'b1;
    end
    show_bal = 1'b0;
  endtask

  task automatic test_blank();
    exp_t e;
    blank_mask = 4'b0100;
    @(negedge clk);
    sb_q.delete();
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({an, seg, frame_start} !== e) begin
        errors++;
        $display("FAIL blank c=%0d: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                 c, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      if (c >= 2 * FRAME) begin
        vectors++;
        if (an === 4'b1011) begin
          errors++;
          $display("FAIL blank_digit2 c=%0d: got an=%b, want anything but 1011", c, an);
        end
      end
    end
    blank_mask = '0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   hit = -1;
    int   first = -1;
    bright = 4'd9;
    @(negedge clk);
    sb_q.delete();
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({an, seg, frame_start} !== e) begin
        errors++;
        $display("FAIL reset_mid c=%0d: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                 c, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      if (hit >= 0 && c == hit + 1) begin
        vectors++;
        if (an !== 4'b1111 || seg !== 7'b1111111) begin
          errors++;
          $display("FAIL reset_mid_dark: got an=%b seg=%b, want 1111 1111111", an, seg);
        end
        rst_n = 1'b1;
      end else if (hit < 0 && an === 4'b1011) begin
        hit = c;
        rst_n = 1'b0;
      end
      if (hit >= 0 && c > hit + 1 && first < 0 && an === 4'b1110) first = c;
    end
    rst_n = 1'b1;
    vectors++;
    if (hit < 0 || first != hit + 6) begin
      errors++;
      $display("FAIL reset_mid_restart: digit2 seen at %0d, digit0 relit at %0d, want %0d",
               hit, first, hit + 6);
    end
    bright = 4'hF;
  endtask

  task automatic test_random();
    exp_t e;
    @(negedge clk);
    sb_q.delete();
    for (int c = 0; c < 4 * FRAME; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({an, seg, frame_start} !== e) begin
        errors++;
        $display("FAIL random c=%0d: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                 c, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      if (c % 8 == 0) begin
        reel_segs  = (N*W)'({$urandom(), $urandom()});
        bal_segs   = (N*W)'({$urandom(), $urandom()});
        show_bal   = 1'($urandom());
        blank_mask = N'($urandom());
        bright     = 4'($urandom());
      end
    end
    blank_mask = '0;
    bright = 4'hF;
  endtask

`ifdef SEG_SCAN_BLINK_EN
  task automatic test_blink();
    exp_t e;
    int   lit0 = 0;
    rst_n = 1'b0;
    blink_mask = 4'b0001;
    blank_mask = '0;
    bright = 4'hF;
    @(negedge clk);
    sb_q.delete();
    for (int c = 0; c < 2 + 66 * FRAME; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({an, seg, frame_start} !== e) begin
        errors++;
        $display("FAIL blink c=%0d: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                 c, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      if (an === 4'b1110) lit0++;
      if (c == 1) rst_n = 1'b1;
    end
    vectors++;
    if (lit0 != 34 * (SLOT - DEAD)) begin
      errors++;
      $display("FAIL blink_digit0_count: got %0d lit clocks, want %0d", lit0, 34 * (SLOT - DEAD));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bright0();
    test_show_bal();
    test_blank();
    test_reset_mid();
    test_random();
`ifdef SEG_SCAN_BLINK_EN
    test_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised time-multiplexed driver for common-anode 7-segment displays.
- Takes per-digit segment patterns for the reel view and the balance view.
- Scans N_DIGITS anodes at a prescaled rate, with ghost-suppression dead time, 16-level brightness PWM and per-digit blanking.
- Sits between the game/score logic and the board segment/anode pins; replaces the fixed 4-digit, every-clock scanner.

Parameters:
- N_DIGITS, 4, number of anodes scanned (2..8).
- SEG_W, 7, segment lines per digit; patterns are active-low.
- SLOT_CLKS, 1024, clocks per digit slot (must be > DEAD_CLKS + 16).
- DEAD_CLKS, 8, clocks at slot start with all anodes off.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- reel_segs  in  N_DIGITS*SEG_W  reel-view patterns; digit 0 is in the LSBs and is the leftmost digit.
- bal_segs  in  N_DIGITS*SEG_W  balance-view patterns, same packing as reel_segs.
- show_bal  in  1  1 = display bal_segs, 0 = display reel_segs.
- blank_mask  in  N_DIGITS  1 = force digit dark.
- bright  in  4  brightness level 0..15; 15 = full on-window.
- seg  out  SEG_W  registered segment drive, active-low.
- an  out  N_DIGITS  registered anode drive, active-low, one-cold or all-ones.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low (rst_n); everything samples on posedge clk.
- Reset values:
  - seg = all ones; an = all ones; frame_start = 0.
  - slot_cnt = 0; dig_idx = 0.
  - Snapshot registers = all ones, i.e. dark.
- Counters:
  - slot_cnt counts 0..SLOT_CLKS-1 and wraps.
  - On wrap, dig_idx increments; after N_DIGITS-1 it wraps to 0.
- Snapshot:
  - Sampled when slot_cnt==SLOT_CLKS-1 and dig_idx==N_DIGITS-1, and in the first cycle after reset release.
  - Captures show_bal, the selected pattern bus, blank_mask and bright.
  - Inputs are frame-consistent: mid-frame changes take effect on the next frame only.
- frame_start is asserted in the cycle where slot_cnt==0 and dig_idx==0, registered with the outputs.
- On-window:
  - on_end = DEAD_CLKS + (((SLOT_CLKS-DEAD_CLKS)*(bright+1))>>4), using integer truncation and width ≥ clog2(SLOT_CLKS)+5.
  - A digit is lit when DEAD_CLKS ≤ slot_cnt < on_end and its snapshot blank bit is 0.
- Output drive:
  - Lit: an = all ones except bit dig_idx = 0; seg = snapshot pattern of dig_idx.
  - Not lit (dead time, PWM off-phase, blanked): an = all ones and seg = all ones.
- Latency: outputs are registered; one clock from counter state to pins.
- The active anode never changes in the same cycle as seg, because dead time brackets every index change.
- An all-ones pattern with the digit unblanked still drives its anode; the segments stay dark.
- Reset mid-scan: the next cycle shows reset values, and scanning restarts at digit 0 with a fresh snapshot.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask (N_DIGITS) and a frame counter; the mask is snapshotted with the other inputs.
  - Digits with a set blink bit are forced dark during frames whose counter bit 5 = 1, i.e. 32 frames on / 32 off.
  - The counter resets to 0.
- Undefined: no blink_mask port and no frame counter; behaviour is exactly as above.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_OFF constant (all ones).
  - Active-low glyph constants for hex 0–F, blank and dash.
  - Function computing on_end.
- Natural sub-module: seg_pwm_slot, which owns slot_cnt/dig_idx and outputs lit, dig_idx and frame_start.
- The top level owns the snapshot registers, selection and output registers.

Test Plan:
- Reset, then release with SLOT_CLKS=32, DEAD_CLKS=4, bright=15 → an stays 1111 for 4+1 clks, then 1110 for 28 clks, then 1111 for 4, then 1101; frame_start pulses every 128 clks.
- bright=0, SLOT_CLKS=32, DEAD_CLKS=4 → on_end=5; each digit is lit for exactly 1 clk per slot.
- reel_segs digit1 = 7'b1111001 ("1"), toggle show_bal with bal_segs digit1 = 7'b0100100 mid-frame → current frame keeps "1"; next frame shows 0100100.
- blank_mask=0100 → an never equals 1011; seg = 1111111 throughout digit 2's slot; other digits unaffected.
- Assert rst_n=0 for 1 clk while digit 2 is lit → next cycle seg=1111111, an=1111; after release, digit 0 is lit again at slot_cnt=DEAD_CLKS.
- With SEG_SCAN_BLINK_EN, blink_mask=0001 → digit 0 is lit in frames 0–31, dark in frames 32–63, lit again from frame 64.
